// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared opcodes, state encoding and error codes for the PE sequencer
// Contents: RV32 major-opcode constants, sequencer state enum, halt error codes,
//           and the opcode classification record produced by pe_op_classify.
package pe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FMADD  = 7'b1000011;
  localparam logic [6:0] OP_FMSUB  = 7'b1000111;
  localparam logic [6:0] OP_FNMSUB = 7'b1001011;
  localparam logic [6:0] OP_FNMADD = 7'b1001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef struct packed {
    logic legal;
    logic is_mem;
    logic is_store;
    logic wr_int;
    logic wr_fp;
    logic is_halt;
  } op_class_t;

endpackage

// File: rtl/pe_op_classify.sv
// rtl/pe_op_classify.sv - combinational opcode classifier for the PE sequencer
// Ports:
//   op_i   in   7  major opcode from the decoder
//   cls_o  out  -  {legal, is_mem, is_store, wr_int, wr_fp, is_halt}
module pe_op_classify
  import pe_pkg::*;
(
  input  logic [6:0] op_i,
  output op_class_t  cls_o
);

  always_comb begin
    cls_o = '0;
    case (op_i)
      OP_R, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        cls_o.legal  = 1'b1;
        cls_o.wr_int = 1'b1;
      end
      OP_LOAD: begin
        cls_o.legal  = 1'b1;
        cls_o.is_mem = 1'b1;
        cls_o.wr_int = 1'b1;
      end
      OP_FLOAD: begin
        cls_o.legal  = 1'b1;
        cls_o.is_mem = 1'b1;
        cls_o.wr_fp  = 1'b1;
      end
      OP_STORE, OP_FSTORE: begin
        cls_o.legal    = 1'b1;
        cls_o.is_mem   = 1'b1;
        cls_o.is_store = 1'b1;
      end
      OP_BRANCH: begin
        cls_o.legal = 1'b1;
      end
      OP_FP, OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        cls_o.legal = 1'b1;
        cls_o.wr_fp = 1'b1;
      end
      OP_SYSTEM: begin
        cls_o.legal   = 1'b1;
        cls_o.is_halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pe_sequencer.sv
// rtl/pe_sequencer.sv - multicycle fetch/decode/execute/memory/writeback control FSM for the PE
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start                           leave IDLE and begin fetching
//   imem_req/addr/valid/rdata       instruction fetch handshake
//   instr, dec_op, dec_complete     latched instruction out, decoder result in
//   exu_start/done, br_taken/target execute handshake and redirect
//   mem_req/we/done                 data-memory handshake
//   rf_we, ff_we                    integer / FP regfile write strobes
//   pc, instret, halted, err        architectural status
module pe_sequencer
  import pe_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned EXU_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic [6:0]  dec_op,
  input  logic        dec_complete,
  output logic        exu_start,
  input  logic        exu_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_done,
  output logic        rf_we,
  output logic        ff_we,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  err
);

  // Counter only needs to hold 0..EXU_TIMEOUT-1.
  localparam int unsigned   TW       = $clog2(EXU_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(EXU_TIMEOUT - 1);

  state_e       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instret_q, instret_d;
  logic [1:0]   err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  op_class_t    cls_q, cls_d;
  logic         brt_q, brt_d;
  logic [31:0]  brtgt_q, brtgt_d;
  op_class_t    cls;

  pe_op_classify u_classify (
    .op_i  (dec_op),
    .cls_o (cls)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      err_q     <= ERR_NONE;
      tmo_q     <= '0;
      cls_q     <= '0;
      brt_q     <= 1'b0;
      brtgt_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      cls_q     <= cls_d;
      brt_q     <= brt_d;
      brtgt_q   <= brtgt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    err_d     = err_q;
    tmo_d     = tmo_q;
    cls_d     = cls_q;
    brt_d     = brt_q;
    brtgt_d   = brtgt_q;
    imem_req  = 1'b0;
    exu_start = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    rf_we     = 1'b0;
    ff_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d = cls;
        tmo_d = '0;
        if (!dec_complete || !cls.legal) begin
          err_d   = ERR_ILLEGAL;
          state_d = ST_HALT;
        end else if (cls.is_halt) begin
          err_d     = ERR_NONE;
          instret_d = instret_q + 32'd1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // The wait counter is cleared on entry and advances every waiting
        // cycle, so it reads zero only in the first EXEC cycle.
        exu_start = (tmo_q == '0);
        if (exu_done) begin
          brt_d   = br_taken;
          brtgt_d = br_target;
          tmo_d   = '0;
          state_d = cls_q.is_mem ? ST_MEM : ST_WB;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls_q.is_store;
        if (mem_done) begin
          state_d = ST_WB;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_HALT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WB: begin
        rf_we     = cls_q.wr_int;
        ff_we     = cls_q.wr_fp;
        instret_d = instret_q + 32'd1;
        pc_d      = brt_q ? brtgt_q : pc_q + 32'd4;
        state_d   = ST_FETCH;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign instret   = instret_q;
  assign err       = err_q;
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_pe_sequencer.sv
// tb/tb_pe_sequencer.sv - self-checking bench for pe_sequencer
module tb_pe_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, imem_valid, exu_done, br_taken, mem_done;
  logic [31:0] imem_rdata, br_target;
  logic        imem_req, exu_start, mem_req, mem_we, rf_we, ff_we, halted;
  logic [31:0] imem_addr, instr, pc, instret;
  logic [6:0]  dec_op;
  logic        dec_complete;
  logic [1:0]  err;

  // Minimal decoder: opcode field straight through, nonzero means complete.
  assign dec_op       = instr[6:0];
  assign dec_complete = (instr[6:0] != 7'd0);

  pe_sequencer #(.RESET_PC(32'h0), .EXU_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr), .dec_op(dec_op), .dec_complete(dec_complete),
    .exu_start(exu_start), .exu_done(exu_done), .br_taken(br_taken), .br_target(br_target),
    .mem_req(mem_req), .mem_we(mem_we), .mem_done(mem_done),
    .rf_we(rf_we), .ff_we(ff_we), .pc(pc), .instret(instret), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst_n; logic start; logic imem_valid; logic [31:0] imem_rdata;
    logic exu_done; logic br_taken; logic [31:0] br_target; logic mem_done;
  } stim_t;

  typedef struct packed {
    logic imem_req; logic exu_start; logic mem_req; logic mem_we; logic rf_we; logic ff_we;
    logic halted; logic [1:0] err; logic [31:0] pc; logic [31:0] instret; logic [31:0] instr;
  } exp_t;

  typedef struct packed { bit legal; bit mem; bit st; bit wi; bit wf; bit sys; } cls_t;

  localparam logic [6:0] LEGAL_OPS [0:16] = '{
    7'b0110011, 7'b1010011, 7'b0010011, 7'b0000011, 7'b0000111, 7'b0100011,
    7'b0100111, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111,
    7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111, 7'b1110011};

  stim_t sq[$];
  exp_t  eq[$];

  // Architectural model state
  logic [31:0] m_pc, m_instret, m_instr;
  logic [1:0]  m_err;
  logic        m_halted;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int seg_cyc, seg_rf, seg_ff, seg_mreq, seg_mwe, rf_at, start_at, halt_at;

  function automatic cls_t tb_class(input logic [6:0] op);
    cls_t c;
    c = '0;
    for (int i = 0; i < 17; i++) if (LEGAL_OPS[i] == op) c.legal = 1'b1;
    c.mem = op inside {7'b0000011, 7'b0000111, 7'b0100011, 7'b0100111};
    c.st  = op inside {7'b0100011, 7'b0100111};
    c.wi  = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    c.wf  = op inside {7'b1010011, 7'b0000111, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
    c.sys = (op == 7'b1110011);
    return c;
  endfunction

  // Random values on every input the current state must ignore.
  function automatic stim_t noise();
    stim_t s;
    s.rst_n      = 1'b1;
    s.start      = 1'($urandom);
    s.imem_valid = 1'b0;
    s.imem_rdata = $urandom;
    s.exu_done   = 1'($urandom);
    s.br_taken   = 1'($urandom);
    s.br_target  = $urandom;
    s.mem_done   = 1'($urandom);
    return s;
  endfunction

  function automatic exp_t mk_exp();
    exp_t e;
    e = '0;
    e.pc      = m_pc;
    e.instret = m_instret;
    e.instr   = m_instr;
    e.halted  = m_halted;
    e.err     = m_err;
    return e;
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic b_reset(input int n);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = noise(); s.rst_n = 1'b0;
      m_pc = 32'h0; m_instret = 32'h0; m_instr = 32'h0; m_err = 2'd0; m_halted = 1'b0;
      push(s, mk_exp());
    end
  endtask

  task automatic b_idle(input int n, input bit go);
    stim_t s;
    for (int i = 0; i < n; i++) begin s = noise(); s.start = 1'b0; push(s, mk_exp()); end
    if (go) begin s = noise(); s.start = 1'b1; push(s, mk_exp()); end
  endtask

  task automatic b_halted(input int n);
    for (int i = 0; i < n; i++) push(noise(), mk_exp());
  endtask

  // One instruction: imem latency, EXEC cycles to done (> TO times out),
  // MEM cycles to done, redirect, and optional reset after 'abort' EXEC cycles.
  task automatic b_instr(input logic [31:0] word, input int ilat, input int elat, input int mlat,
                         input bit taken, input logic [31:0] tgt, input int abort);
    stim_t s; exp_t e; cls_t c; bit done;
    for (int i = 0; i < ilat; i++) begin
      s = noise(); e = mk_exp(); e.imem_req = 1'b1; push(s, e);
    end
    s = noise(); s.imem_valid = 1'b1; s.imem_rdata = word;
    e = mk_exp(); e.imem_req = 1'b1; push(s, e);
    m_instr = word;
    push(noise(), mk_exp());
    c = tb_class(word[6:0]);
    if (!c.legal) begin m_halted = 1'b1; m_err = 2'd1; return; end
    if (c.sys) begin m_instret = m_instret + 1; m_halted = 1'b1; m_err = 2'd0; return; end
    done = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      if (abort != 0 && k > abort) begin b_reset(1); return; end
      s = noise(); s.exu_done = 1'b0;
      e = mk_exp(); e.exu_start = (k == 1);
      if (k == elat) begin
        s.exu_done = 1'b1; s.br_taken = taken; s.br_target = tgt; done = 1'b1;
      end
      push(s, e);
      if (done) break;
    end
    if (!done) begin m_halted = 1'b1; m_err = 2'd2; return; end
    if (c.mem) begin
      done = 1'b0;
      for (int k = 1; k <= TO; k++) begin
        s = noise(); s.mem_done = (k == mlat);
        e = mk_exp(); e.mem_req = 1'b1; e.mem_we = c.st;
        done = (k == mlat);
        push(s, e);
        if (done) break;
      end
      if (!done) begin m_halted = 1'b1; m_err = 2'd2; return; end
    end
    e = mk_exp(); e.rf_we = c.wi; e.ff_we = c.wf;
    push(noise(), e);
    m_instret = m_instret + 1;
    m_pc = taken ? tgt : m_pc + 32'd4;
  endtask

  task automatic chk1(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, expv);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, expv);
    end
  endtask

  task automatic seg_clear();
    seg_cyc = 0; seg_rf = 0; seg_ff = 0; seg_mreq = 0; seg_mwe = 0;
    rf_at = -1; start_at = -1; halt_at = -1;
  endtask

  // Drive queued stimulus; compare every cycle at the falling edge.
  task automatic run_q();
    stim_t s; exp_t e;
    while (sq.size() != 0) begin
      s = sq.pop_front();
      e = eq.pop_front();
      rst_n = s.rst_n; start = s.start; imem_valid = s.imem_valid; imem_rdata = s.imem_rdata;
      exu_done = s.exu_done; br_taken = s.br_taken; br_target = s.br_target; mem_done = s.mem_done;
      @(negedge clk);
      chk1("imem_req", imem_req, e.imem_req);
      chk32("imem_addr", imem_addr, e.pc);
      chk1("exu_start", exu_start, e.exu_start);
      chk1("mem_req", mem_req, e.mem_req);
      if (e.mem_req) chk1("mem_we", mem_we, e.mem_we);
      chk1("rf_we", rf_we, e.rf_we);
      chk1("ff_we", ff_we, e.ff_we);
      chk32("pc", pc, e.pc);
      chk32("instret", instret, e.instret);
      chk32("instr", instr, e.instr);
      chk1("halted", halted, e.halted);
      if (e.halted) chk32("err", {30'd0, err}, {30'd0, e.err});
      if (rf_we) begin seg_rf++; if (rf_at < 0) rf_at = seg_cyc; end
      if (ff_we) seg_ff++;
      if (mem_req) seg_mreq++;
      if (mem_req && mem_we) seg_mwe++;
      if (exu_start && start_at < 0) start_at = seg_cyc;
      if (halted && halt_at < 0) halt_at = seg_cyc;
      seg_cyc++;
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [6:0]  op;
    cls_t        c;
    bit          tk;
    rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    exu_done = 1'b0; br_taken = 1'b0; br_target = '0; mem_done = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then ADDI with done one cycle after exu_start.
    b_reset(2);
    b_idle(1, 1);
    run_q();
    seg_clear();
    b_instr(32'h0050_0093, 0, 2, 0, 1'b0, 32'h0, 0);
    run_q();
    chk32("t2_wb_cycle", rf_at, 32'd4);
    chk32("t2_rf_pulses", seg_rf, 32'd1);
    chk32("t2_pc", pc, 32'h4);
    chk32("t2_instret", instret, 32'd1);

    // SW with mem_done after 3 cycles.
    seg_clear();
    b_instr(32'h0020_A023, 1, 1, 3, 1'b0, 32'h0, 0);
    run_q();
    chk32("t3_mem_req_cycles", seg_mreq, 32'd3);
    chk32("t3_mem_we_cycles", seg_mwe, 32'd3);
    chk32("t3_regfile_writes", seg_rf + seg_ff, 32'd0);
    chk32("t3_pc", pc, 32'h8);

    // Taken branch, then wrap of pc+4 from 0xFFFF_FFFC.
    seg_clear();
    b_instr(32'h0020_8463, 0, 1, 0, 1'b1, 32'h40, 0);
    run_q();
    chk32("t4_branch_pc", pc, 32'h40);
    chk32("t4_branch_rf", seg_rf, 32'd0);
    b_instr(32'h0000_006F, 0, 3, 0, 1'b1, 32'hFFFF_FFFC, 0);
    b_instr(32'h0050_0093, 2, 1, 0, 1'b0, 32'h0, 0);
    run_q();
    chk32("t4_wrap_pc", pc, 32'h0);
    chk32("t4_instret", instret, 32'd5);

    // Done on the last allowed cycle in both EXEC and MEM.
    b_instr(32'h0000_A103, 0, TO, TO, 1'b0, 32'h0, 0);
    run_q();
    chk32("edge_instret", instret, 32'd6);
    chk32("edge_pc", pc, 32'h4);

    // Reset mid-EXEC.
    b_instr(32'h0050_0093, 0, 20, 0, 1'b0, 32'h0, 2);
    run_q();
    chk32("t1_pc", pc, 32'h0);
    chk32("t1_instret", instret, 32'd0);
    chk1("t1_exu_start", exu_start, 1'b0);
    chk1("t1_rf_we", rf_we, 1'b0);
    chk1("t1_imem_req", imem_req, 1'b0);

    // Illegal opcode after one retire.
    b_idle(1, 1);
    b_instr(32'h0050_0093, 0, 1, 0, 1'b0, 32'h0, 0);
    b_instr(32'h0000_007F, 0, 1, 0, 1'b0, 32'h0, 0);
    b_halted(3);
    run_q();
    chk1("t5_halted", halted, 1'b1);
    chk32("t5_err", {30'd0, err}, 32'd1);
    chk32("t5_instret", instret, 32'd1);

    // EXEC timeout, then ECALL.
    b_reset(2);
    b_idle(1, 1);
    seg_clear();
    b_instr(32'h0050_0093, 0, TO + 1, 0, 1'b0, 32'h0, 0);
    b_halted(2);
    run_q();
    chk32("t6_exec_len", halt_at - start_at, 32'd8);
    chk32("t6_err", {30'd0, err}, 32'd2);
    chk32("t6_instret", instret, 32'd0);
    b_reset(2);
    b_idle(0, 1);
    b_instr(32'h0000_0073, 0, 1, 0, 1'b0, 32'h0, 0);
    b_halted(2);
    run_q();
    chk32("t6_ecall_err", {30'd0, err}, 32'd0);
    chk1("t6_ecall_halted", halted, 1'b1);
    chk32("t6_ecall_instret", instret, 32'd1);

    // Randomized programs against the model.
    for (int r = 0; r < 30; r++) begin
      b_reset($urandom_range(1, 2));
      b_idle($urandom_range(0, 3), 1'b1);
      for (int k = 0; k < 25; k++) begin
        if ($urandom_range(0, 19) == 0) begin
          op = 7'($urandom);
          c  = tb_class(op);
          while (c.legal) begin op = 7'($urandom); c = tb_class(op); end
        end else begin
          op = LEGAL_OPS[$urandom_range(0, 16)];
        end
        w = $urandom;
        w[6:0] = op;
        tk = (op inside {7'b1100011, 7'b1101111, 7'b1100111}) ? 1'($urandom) : 1'b0;
        b_instr(w, $urandom_range(0, 3), $urandom_range(1, TO + 1), $urandom_range(1, TO + 1),
                tk, $urandom, 0);
        if (m_halted) begin b_halted(2); break; end
      end
      run_q();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
